// File: rtl/ram_spi_pkg.sv
// ram_spi_pkg: shared FSM state type, counter-width helper and parity-bit count for ram_spi_reader
// Parity bit appended only when RAM_SPI_PARITY_EN is defined.
package ram_spi_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`ifdef RAM_SPI_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/ram_spi_reader_if.sv
// ram_spi_reader_if: write port, read request and SPI output bundle
// master: drives we/wr_addr/wr_data/rd_start/rd_addr, observes busy/done/q/cs_n/sclk/sdo
// slave:  the ram_spi_reader side
interface ram_spi_reader_if #(parameter int WIDTH = 8, parameter int AW = 4);
    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_start;
    logic [AW-1:0]    rd_addr;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic             cs_n;
    logic             sclk;
    logic             sdo;
    modport master (output we, wr_addr, wr_data, rd_start, rd_addr,
                    input busy, done, q, cs_n, sclk, sdo);
    modport slave  (input we, wr_addr, wr_data, rd_start, rd_addr,
                    output busy, done, q, cs_n, sclk, sdo);
endinterface

// File: rtl/spi_bit_timer.sv
// spi_bit_timer: HALF_DIV divider generating sclk (idle low) and the fall_tick bit-end strobe
// Ports: clk, rst, en (run while high, else held idle), sclk, fall_tick (high in the cycle whose edge drops sclk)
module spi_bit_timer
    import ram_spi_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic fall_tick
);
    localparam int DW = cnt_w(HALF_DIV);
    logic [DW-1:0] cnt;
    logic          half_end;
    assign half_end  = en && cnt == DW'(HALF_DIV - 1);
    assign fall_tick = half_end && sclk;
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt  <= half_end ? '0 : cnt + 1'b1;
            sclk <= sclk ^ half_end;
        end
    end
endmodule

// File: rtl/ram_spi_reader.sv
// ram_spi_reader: word RAM with parallel write port and SPI mode-0 serial readout of one word per request
// Ports: clk, rst (sync, active high), bus (ram_spi_reader_if.slave: write port, rd_start/rd_addr,
//        busy/done/q status, cs_n/sclk/sdo SPI outputs)
// Define RAM_SPI_PARITY_EN to append an even-parity bit after the data bits.
module ram_spi_reader
    import ram_spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int HALF_DIV  = 2,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    ram_spi_reader_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int NBITS = WIDTH + PAR_BITS;
    localparam int BW    = cnt_w(NBITS);
    state_t           state, nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rd_word, ordered, word, q_r;
    logic [NBITS-1:0] frame, load_frame;
    logic [BW-1:0]    bcnt;
    logic             last, fall_tick, sclk, done_r, cs_n_r, sdo_r;
    spi_bit_timer #(.HALF_DIV(HALF_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (state == SHIFT),
        .sclk      (sclk),
        .fall_tick (fall_tick)
    );
    always_ff @(posedge clk) begin
        if (bus.we)
            mem[bus.wr_addr] <= bus.wr_data;
    end
    assign rd_word = mem[addr];
    // The frame always shifts out of its top bit, so bit order is fixed at load time.
    always_comb begin
        ordered = '0;
        for (int i = 0; i < WIDTH; i++)
            ordered[i] = MSB_FIRST ? rd_word[i] : rd_word[WIDTH-1-i];
    end
`ifdef RAM_SPI_PARITY_EN
    assign load_frame = {ordered, ^rd_word};
`else
    assign load_frame = ordered;
`endif
    assign last = bcnt == BW'(NBITS - 1);
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.rd_start ? LOAD : IDLE;
            LOAD:    nxt = SHIFT;
            SHIFT:   nxt = (fall_tick && last) ? DONE : SHIFT;
            default: nxt = IDLE;
        endcase
    end
    // The final falling edge closes the frame, so cs_n/done take their DONE values exactly in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            word   <= '0;
            frame  <= '0;
            bcnt   <= '0;
            q_r    <= '0;
            done_r <= 1'b0;
            cs_n_r <= 1'b1;
            sdo_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.rd_start) addr <= bus.rd_addr;
                LOAD: begin
                    word   <= rd_word;
                    frame  <= load_frame;
                    sdo_r  <= load_frame[NBITS-1];
                    cs_n_r <= 1'b0;
                    bcnt   <= '0;
                end
                SHIFT: if (fall_tick) begin
                    if (last) begin
                        cs_n_r <= 1'b1;
                        sdo_r  <= 1'b0;
                        done_r <= 1'b1;
                        q_r    <= word;
                    end else begin
                        frame <= frame << 1;
                        sdo_r <= frame[NBITS-2];
                        bcnt  <= bcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = done_r;
    assign bus.q    = q_r;
    assign bus.cs_n = cs_n_r;
    assign bus.sclk = sclk;
    assign bus.sdo  = sdo_r;
endmodule

// File: tb/tb_ram_spi_reader.sv
// tb_ram_spi_reader: table-driven check of MSB-first and LSB-first readers plus busy, same-cycle write and reset corner cases
module tb_ram_spi_reader;
    localparam int W = 8;
    localparam int D = 16;
    localparam int H = 2;
`ifdef RAM_SPI_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int FRAME = NB * 2 * H;
    localparam int WIN   = FRAME + 30;
    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp_lsb;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we, rs;
    logic [3:0] wa, ra;
    logic [7:0] wd;
    int         n_chk = 0;
    int         n_fail = 0;
    vec_t       vecs [7];
    ram_spi_reader_if #(.WIDTH(W), .AW(4)) bm ();
    ram_spi_reader_if #(.WIDTH(W), .AW(4)) bl ();
    assign bm.we = we;  assign bm.wr_addr = wa;  assign bm.wr_data = wd;
    assign bm.rd_start = rs;  assign bm.rd_addr = ra;
    assign bl.we = we;  assign bl.wr_addr = wa;  assign bl.wr_data = wd;
    assign bl.rd_start = rs;  assign bl.rd_addr = ra;
    ram_spi_reader #(.WIDTH(W), .DEPTH(D), .HALF_DIV(H), .MSB_FIRST(1)) dut (
        .clk (clk), .rst (rst), .bus (bm)
    );
    ram_spi_reader #(.WIDTH(W), .DEPTH(D), .HALF_DIV(H), .MSB_FIRST(0)) dut_lsb (
        .clk (clk), .rst (rst), .bus (bl)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [NB-1:0] frame_of(input logic [7:0] bits, input logic [7:0] data);
`ifdef RAM_SPI_PARITY_EN
        return {bits, ^data};
`else
        return bits + 8'(data & 8'h00);
`endif
    endfunction
    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask
    task automatic do_read(input logic [3:0] a, input int extra, input bit load_wr, input logic [7:0] load_data,
                           output logic [NB-1:0] cm, output logic [NB-1:0] cl,
                           output int nbm, output int nbl, output int low, output int dn);
        logic pm, pl;
        cm = '0; cl = '0; nbm = 0; nbl = 0; low = 0; dn = 0; pm = 1'b0; pl = 1'b0;
        @(negedge clk);
        rs = 1'b1; ra = a;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("busy_after_start", 32'(bm.busy), 1);
                chk("cs_n_high_in_load", 32'(bm.cs_n), 1);
            end
            if (k == 1) chk("cs_n_low_at_2", 32'(bm.cs_n), 0);
            if (bm.sclk && !pm) begin cm = {cm[NB-2:0], bm.sdo}; nbm++; end
            if (bl.sclk && !pl) begin cl = {cl[NB-2:0], bl.sdo}; nbl++; end
            pm = bm.sclk;
            pl = bl.sclk;
            if (!bm.cs_n) low++;
            if (bm.done) begin
                dn++;
                chk("busy_with_done", 32'(bm.busy), 1);
            end
            rs = (k == extra);
            we = load_wr && k == 0;
            wa = a;
            wd = load_data;
        end
    endtask
    initial begin
        logic [NB-1:0] cm, cl;
        int nbm, nbl, low, dn, cnt_done, cnt_low;
        bit seen;
        vecs[0] = '{4'd3,  8'hA5, 8'hA5};
        vecs[1] = '{4'd0,  8'h01, 8'h80};
        vecs[2] = '{4'd15, 8'hC6, 8'h63};
        vecs[3] = '{4'd7,  8'h12, 8'h48};
        vecs[4] = '{4'd9,  8'hFF, 8'hFF};
        vecs[5] = '{4'd1,  8'h00, 8'h00};
        vecs[6] = '{4'd5,  8'h07, 8'hE0};
        we = 1'b0; rs = 1'b0; wa = '0; wd = '0; ra = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bm.busy), 0);
        chk("rst_done", 32'(bm.done), 0);
        chk("rst_q", 32'(bm.q), 0);
        chk("rst_cs_n", 32'(bm.cs_n), 1);
        chk("rst_sclk", 32'(bm.sclk), 0);
        chk("rst_sdo", 32'(bm.sdo), 0);
        chk("rst_cs_n_lsb", 32'(bl.cs_n), 1);
        rst = 1'b0;
        foreach (vecs[i]) write_word(vecs[i].addr, vecs[i].data);
        foreach (vecs[i]) begin
            do_read(vecs[i].addr, -1, 1'b0, 8'h00, cm, cl, nbm, nbl, low, dn);
            chk($sformatf("frame_msb[%0d]", i), 32'(cm), 32'(frame_of(vecs[i].data, vecs[i].data)));
            chk($sformatf("frame_lsb[%0d]", i), 32'(cl), 32'(frame_of(vecs[i].exp_lsb, vecs[i].data)));
            chk($sformatf("nbits_msb[%0d]", i), 32'(nbm), 32'(NB));
            chk($sformatf("nbits_lsb[%0d]", i), 32'(nbl), 32'(NB));
            chk($sformatf("cs_low_cycles[%0d]", i), 32'(low), 32'(FRAME));
            chk($sformatf("done_count[%0d]", i), 32'(dn), 1);
            chk($sformatf("q_msb[%0d]", i), 32'(bm.q), 32'(vecs[i].data));
            chk($sformatf("q_lsb[%0d]", i), 32'(bl.q), 32'(vecs[i].data));
            chk($sformatf("busy_idle[%0d]", i), 32'(bm.busy), 0);
        end
        do_read(4'd3, 12, 1'b0, 8'h00, cm, cl, nbm, nbl, low, dn);
        chk("busy_restart_done", 32'(dn), 1);
        chk("busy_restart_low", 32'(low), 32'(FRAME));
        chk("busy_restart_frame", 32'(cm), 32'(frame_of(8'hA5, 8'hA5)));
        do_read(4'd3, -1, 1'b1, 8'hFF, cm, cl, nbm, nbl, low, dn);
        chk("load_write_old_frame", 32'(cm), 32'(frame_of(8'hA5, 8'hA5)));
        chk("load_write_old_q", 32'(bm.q), 32'hA5);
        do_read(4'd3, -1, 1'b0, 8'h00, cm, cl, nbm, nbl, low, dn);
        chk("load_write_new_frame", 32'(cm), 32'(frame_of(8'hFF, 8'hFF)));
        chk("load_write_new_q", 32'(bm.q), 32'hFF);
        @(negedge clk);
        rs = 1'b1; ra = 4'd15;
        @(negedge clk);
        rs = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bm.sclk;
        end
        chk("mid_rst_sclk_seen", 32'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs_n", 32'(bm.cs_n), 1);
        chk("mid_rst_sclk", 32'(bm.sclk), 0);
        chk("mid_rst_busy", 32'(bm.busy), 0);
        chk("mid_rst_done", 32'(bm.done), 0);
        chk("mid_rst_sdo", 32'(bm.sdo), 0);
        rst = 1'b0;
        cnt_done = 0;
        cnt_low = 0;
        repeat (FRAME + 10) begin
            @(negedge clk);
            if (bm.done) cnt_done++;
            if (!bm.cs_n) cnt_low++;
        end
        chk("mid_rst_no_done", 32'(cnt_done), 0);
        chk("mid_rst_no_frame", 32'(cnt_low), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
